// File: rtl/crc_write_ctrl_pkg.sv
// Shared types and helpers for the write-CRC sequencer and its per-byte-lane generator.
// CRC-8 is polynomial x^8+x^2+x+1 with a zero seed, run over a 64-bit lane message from the MSB down.
package crc_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, COLLECT, FLUSH, CALC, APPEND} crc_ctrl_state_t;

    localparam int BURST_BEATS = 8;
    localparam int LANE_BITS   = 8 * BURST_BEATS;

    function automatic logic [7:0] crc8_64(input logic [LANE_BITS-1:0] msg);
        logic [7:0] c;
        c = 8'h00;
        for (int i = LANE_BITS - 1; i >= 0; i--) begin
            if (c[7] ^ msg[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else               c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_write_ctrl_crc.sv
// Per-byte-lane CRC-8 generator: the first 8 enables shift in one burst, and the 9th enable computes the code.
// Each lane builds a 64-bit message with beat 0 in the low byte; the code is registered and held until the next compute.
module crc
    import crc_ctrl_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_crc_en,
    input  logic [2*N-1:0] i_crc_in_data,
    output logic [2*N-1:0] o_crc_code
);

    localparam int W     = 2 * N;
    localparam int LANES = W / 8;

    logic [3:0]                          cnt_q, cnt_d;
    logic [LANES-1:0][LANE_BITS-1:0]     msg_q, msg_d;
    logic [W-1:0]                        code_q, code_d;

    always_comb begin
        cnt_d  = cnt_q;
        msg_d  = msg_q;
        code_d = code_q;
        if (i_crc_en) begin
            if (cnt_q == 4'(BURST_BEATS)) begin
                for (int l = 0; l < LANES; l++) code_d[l*8 +: 8] = crc8_64(msg_q[l]);
                cnt_d = 4'd0;
            end else begin
                for (int l = 0; l < LANES; l++)
                    msg_d[l] = {i_crc_in_data[l*8 +: 8], msg_q[l][LANE_BITS-1:8]};
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_q  <= '0;
            msg_q  <= '0;
            code_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            msg_q  <= msg_d;
            code_q <= code_d;
        end
    end

    assign o_crc_code = code_q;

endmodule

// File: rtl/crc_write_ctrl.sv
// Write-path sequencer: takes 8-beat bursts, feeds the CRC generator, and forwards beats to the DQ serializer.
// With CRC on, the burst is followed by a FLUSH and a CALC bubble, then the generator's code is muxed out as one extra beat.
module crc_write_ctrl
    import crc_ctrl_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_crc_mode,
    input  logic           i_wr_valid,
    input  logic [2*N-1:0] i_wr_data,
    output logic           o_ready,
    output logic           o_crc_en,
    output logic [2*N-1:0] o_crc_in_data,
    output logic [2*N-1:0] o_crc_code,
    output logic           o_dq_valid,
    output logic [2*N-1:0] o_dq_data,
    output logic           o_dq_is_crc,
    output logic           o_burst_done
);

    localparam int W = 2 * N;

    crc_ctrl_state_t state_q, state_d;
    logic [2:0]      beat_cnt_q, beat_cnt_d;
    logic            mode_q, mode_d;
    logic            crc_en_q, crc_en_d;
    logic [W-1:0]    crc_in_q, crc_in_d;
    logic            dq_valid_q, dq_valid_d;
    logic [W-1:0]    dq_data_q, dq_data_d;
    logic            is_crc_q, is_crc_d;
    logic            done_q, done_d;
    logic            accept;
    logic            beat_mode;
    logic [W-1:0]    crc_code;

    assign o_ready   = (state_q == IDLE) || (state_q == COLLECT);
    assign accept    = i_wr_valid && o_ready;
    // The first beat of a burst uses the live mode input; later beats use the latched one.
    assign beat_mode = (state_q == IDLE) ? i_crc_mode : mode_q;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        mode_d     = mode_q;
        crc_en_d   = accept && beat_mode;
        crc_in_d   = (accept && beat_mode) ? i_wr_data : '0;
        dq_valid_d = accept;
        dq_data_d  = accept ? i_wr_data : '0;
        is_crc_d   = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d     = i_crc_mode;
                    beat_cnt_d = 3'd1;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if (beat_cnt_q == 3'(BURST_BEATS - 1)) begin
                        if (mode_q) begin
                            state_d = FLUSH;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                // Extra zero-data enable is the generator's compute strobe.
                crc_en_d = 1'b1;
                state_d  = CALC;
            end
            CALC: begin
                dq_valid_d = 1'b1;
                is_crc_d   = 1'b1;
                done_d     = 1'b1;
                state_d    = APPEND;
            end
            APPEND:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            mode_q     <= 1'b0;
            crc_en_q   <= 1'b0;
            crc_in_q   <= '0;
            dq_valid_q <= 1'b0;
            dq_data_q  <= '0;
            is_crc_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            mode_q     <= mode_d;
            crc_en_q   <= crc_en_d;
            crc_in_q   <= crc_in_d;
            dq_valid_q <= dq_valid_d;
            dq_data_q  <= dq_data_d;
            is_crc_q   <= is_crc_d;
            done_q     <= done_d;
        end
    end

    crc #(.N(N)) u_crc (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_crc_en      (o_crc_en),
        .i_crc_in_data (o_crc_in_data),
        .o_crc_code    (crc_code)
    );

    assign o_crc_en      = crc_en_q;
    assign o_crc_in_data = crc_in_q;
    assign o_crc_code    = crc_code;
    assign o_dq_valid    = dq_valid_q;
    assign o_dq_data     = (state_q == APPEND) ? crc_code : dq_data_q;
    assign o_dq_is_crc   = is_crc_q;
    assign o_burst_done  = done_q;

endmodule

// File: tb/tb_crc_write_ctrl.sv
// Directed bench for crc_write_ctrl: an N=4 instance for most scenarios and an N=16 instance for the reset/multi-lane case.
// Expected CRC-8 (poly 0x07, seed 0) of 64'h0807060504030201 is 8'h58 (computed by hand).
module tb_crc_write_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic        m4, v4, rdy4, cen4, dqv4, isc4, done4;
    logic [7:0]  d4, cin4, code4, dqd4;
    logic        m16, v16, rdy16, cen16, dqv16, isc16, done16;
    logic [31:0] d16, cin16, code16, dqd16;

    always #5 clk = ~clk;

    crc_write_ctrl #(.N(4)) dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_crc_mode(m4), .i_wr_valid(v4), .i_wr_data(d4),
        .o_ready(rdy4), .o_crc_en(cen4), .o_crc_in_data(cin4), .o_crc_code(code4),
        .o_dq_valid(dqv4), .o_dq_data(dqd4), .o_dq_is_crc(isc4), .o_burst_done(done4)
    );

    crc_write_ctrl #(.N(16)) dut16 (
        .i_clk(clk), .i_reset(rst_n), .i_crc_mode(m16), .i_wr_valid(v16), .i_wr_data(d16),
        .o_ready(rdy16), .o_crc_en(cen16), .o_crc_in_data(cin16), .o_crc_code(code16),
        .o_dq_valid(dqv16), .o_dq_data(dqd16), .o_dq_is_crc(isc16), .o_burst_done(done16)
    );

    // Vector layout: {ready, dq_valid, dq_data, is_crc, burst_done, crc_en, crc_in_data}
    task automatic test_reset();
        rst_n = 1'b0; v4 = 1'b1; d4 = 8'hFF; m4 = 1'b1; v16 = 1'b1; d16 = '1; m16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; v4 = 1'b0; d4 = 8'h00; m4 = 1'b0; v16 = 1'b0; d16 = '0; m16 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({rdy4, dqv4, dqd4, isc4, done4, cen4, cin4} !== {1'b1, 20'h0}) begin
                errors++;
                $display("FAIL reset4 cycle %0d got %h exp %h", c,
                         {rdy4, dqv4, dqd4, isc4, done4, cen4, cin4}, {1'b1, 20'h0});
            end
            checks++;
            if ({rdy16, dqv16, dqd16, isc16, done16, cen16, cin16} !== {1'b1, 68'h0}) begin
                errors++;
                $display("FAIL reset16 cycle %0d got %h exp %h", c,
                         {rdy16, dqv16, dqd16, isc16, done16, cen16, cin16}, {1'b1, 68'h0});
            end
            @(posedge clk); #1;
        end
    endtask

    // Beat k carries step*(k+1); the mode input toggles after beat 0 and must be ignored.
    task automatic test_crc_burst(input logic [7:0] step, input logic [7:0] exp_code, input string name);
        logic [20:0] exp, got;
        logic [7:0]  dat;
        for (int c = 0; c < 13; c++) begin
            v4 = (c < 8);
            d4 = (c < 8) ? 8'(step * (c + 1)) : 8'hA5;
            m4 = (c == 0) ? 1'b1 : 1'(c % 2);
            @(negedge clk);
            dat = (c >= 1 && c <= 8) ? 8'(step * c) : 8'h00;
            exp = {!(c >= 8 && c <= 10),
                   (c >= 1 && c <= 8) || (c == 10),
                   (c == 10) ? exp_code : dat,
                   c == 10, c == 10,
                   c >= 1 && c <= 9,
                   dat};
            got = {rdy4, dqv4, dqd4, isc4, done4, cen4, cin4};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d got %h exp %h", name, c, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_crc_off_back_to_back();
        logic [20:0] exp, got;
        logic [7:0]  dat;
        for (int c = 0; c < 19; c++) begin
            v4 = (c < 16);
            d4 = (c < 16) ? 8'(8'h10 + c) : 8'h5A;
            m4 = (c == 0 || c == 8) ? 1'b0 : 1'b1;
            @(negedge clk);
            dat = (c >= 1 && c <= 16) ? 8'(8'h10 + c - 1) : 8'h00;
            exp = {1'b1, (c >= 1 && c <= 16), dat, 1'b0, (c == 8 || c == 16), 1'b0, 8'h00};
            got = {rdy4, dqv4, dqd4, isc4, done4, cen4, cin4};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL crc_off_b2b cycle %0d got %h exp %h", c, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // Beats 0..3 in cycles 0..3, a 3-cycle valid gap, beats 4..7 in cycles 7..10.
    task automatic test_valid_gap();
        logic [20:0] exp, got;
        logic [7:0]  dat;
        logic        dv;
        for (int c = 0; c < 17; c++) begin
            v4 = (c < 4) || (c >= 7 && c <= 10);
            d4 = (c < 4) ? 8'(c + 1) : ((c >= 7 && c <= 10) ? 8'(c - 2) : 8'hC3);
            m4 = (c == 0);
            @(negedge clk);
            dv  = (c >= 1 && c <= 4) || (c >= 8 && c <= 11);
            dat = (c >= 1 && c <= 4) ? 8'(c) : ((c >= 8 && c <= 11) ? 8'(c - 3) : 8'h00);
            exp = {!(c >= 11 && c <= 13), dv || (c == 13), (c == 13) ? 8'h58 : dat,
                   c == 13, c == 13, dv || (c == 12), dat};
            got = {rdy4, dqv4, dqd4, isc4, done4, cen4, cin4};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL valid_gap cycle %0d got %h exp %h", c, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // N=16: partial burst, reset, then a full burst with lanes 0..2 = 01..08 and lane 3 = 00.
    task automatic test_reset_mid_burst();
        logic [68:0] exp, got;
        logic [31:0] dat;
        for (int c = 0; c < 6; c++) begin
            v16 = 1'b1; d16 = 32'hDEAD_0000 + c; m16 = 1'b1;
            @(posedge clk); #1;
        end
        rst_n = 1'b0; v16 = 1'b1; d16 = 32'h1234_5678;
        @(posedge clk); #1;
        rst_n = 1'b1; v16 = 1'b0; d16 = '0; m16 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            got = {rdy16, dqv16, dqd16, isc16, done16, cen16, cin16};
            checks++;
            if (got !== {1'b1, 68'h0}) begin
                errors++;
                $display("FAIL rst_mid_idle cycle %0d got %h exp %h", c, got, {1'b1, 68'h0});
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 13; c++) begin
            v16 = (c < 8);
            d16 = (c < 8) ? {8'h00, 8'(c + 1), 8'(c + 1), 8'(c + 1)} : 32'hFFFF_FFFF;
            m16 = (c == 0);
            @(negedge clk);
            dat = (c >= 1 && c <= 8) ? {8'h00, 8'(c), 8'(c), 8'(c)} : 32'h0;
            exp = {!(c >= 8 && c <= 10), (c >= 1 && c <= 8) || (c == 10),
                   (c == 10) ? 32'h0058_5858 : dat, c == 10, c == 10, c >= 1 && c <= 9, dat};
            got = {rdy16, dqv16, dqd16, isc16, done16, cen16, cin16};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rst_mid_burst cycle %0d got %h exp %h", c, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m4 = 1'b0; v4 = 1'b0; d4 = '0;
        m16 = 1'b0; v16 = 1'b0; d16 = '0;
        test_reset();
        test_crc_burst(8'h00, 8'h00, "crc_zero");
        test_crc_burst(8'h01, 8'h58, "crc_count");
        test_crc_off_back_to_back();
        test_valid_gap();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
